farm_sensor_request: RTL and testbench
======================================

Name: farm_sensor_request

Overview:
- Vehicle-detector front end for the farm-road approach of the highway/farm traffic-light controller.
- Conditions the raw loop-sensor input and qualifies vehicle presence.
- Produces the latched request `C` that the controller consumes, and releases it once the controller grants farm green (`farm_light` = 3'b001).
- Also reports waiting-vehicle count, wait time and an urgency flag for the 7-segment/status logic.

Parameters:
- TICK_CYC, 50_000_000, clk cycles per 1 s tick (50 MHz board clock)
- DEBOUNCE_CYC, 500_000, consecutive stable synced cycles needed to change the debounced level (10 ms)
- MIN_PRESENCE_S, 2, ticks of continuous presence before a request is raised
- MAX_WAIT_S, 9, ticks waiting in REQUEST after which urgent asserts

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sensor_raw  in  1  asynchronous loop-sensor input, 1 = vehicle present
- farm_light  in  3  farm-road lamp state from controller, one-hot {red,yellow,green}: 001 green, 010 yellow, 100 red
- C  out  1  registered vehicle request to controller
- waiting_cnt  out  4  vehicles arrived since last service, saturates at 15
- wait_s  out  8  seconds spent in REQUEST, saturates at 255
- urgent  out  1  wait_s >= MAX_WAIT_S while in REQUEST

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync flops, debounced level `deb`, all counters and all outputs go to 0.
  - State goes to IDLE.
  - Applies from any state, mid-operation included.
- Synchronizer: 2-flop chain on sensor_raw.
- Debounce:
  - Counter increments while synced != deb and clears whenever synced == deb.
  - When the counter reaches DEBOUNCE_CYC, deb toggles and the counter clears.
  - A clean raw edge therefore reaches deb exactly 2+DEBOUNCE_CYC cycles later.
  - Glitches shorter than DEBOUNCE_CYC cycles never change deb.
- Vehicle count: each deb rising edge increments waiting_cnt, saturating at 15 (no wrap). It clears on entry to SERVED.
- Tick generator:
  - Counter runs 0..TICK_CYC-1; a tick pulse fires in the cycle the counter equals TICK_CYC-1.
  - The counter restarts at 0 on every entry to DETECT or REQUEST, so all durations are exact.
- Green detect: green = (farm_light == 3'b001). Any non-one-hot value counts as not green.
- FSM states (in priority order within each state):
  - IDLE: C=0.
    - green=0 and deb=1 -> DETECT.
    - Otherwise stay (a vehicle arriving during green is ignored; it is served by the current green).
  - DETECT: C=0; presence counter counts ticks.
    - green=1 -> SERVED.
    - deb=0 -> IDLE (spurious/departed).
    - presence reaches MIN_PRESENCE_S -> REQUEST.
  - REQUEST: C=1, registered, asserted in the first cycle in REQUEST.
    - wait_s increments on each tick, saturating at 255.
    - green=1 -> SERVED.
    - deb falling does NOT cancel; the request is latched.
  - SERVED: C=0 from the first cycle in SERVED.
    - wait_s cleared to 0; waiting_cnt cleared on entry.
    - Leaves to IDLE when green=0.
    - If deb is still 1, IDLE re-enters DETECT one cycle later.
- urgent: registered; 1 only in REQUEST with wait_s >= MAX_WAIT_S; 0 in all other states.
- Simultaneous events in the same cycle:
  - deb rise + green: count increments, then clears on SERVED entry; the clear wins.
  - tick + green in REQUEST: go to SERVED, wait_s = 0.
- Latency: clean raw rise to C=1 is 2+DEBOUNCE_CYC+1+MIN_PRESENCE_S*TICK_CYC cycles. Green to C=0 is 1 cycle.

Decomposition:
- Shared package traffic_pkg (shared with the light controllers):
  - Lamp constants LIGHT_GREEN=3'b001, LIGHT_YELLOW=3'b010, LIGHT_RED=3'b100.
  - Sensor FSM enum {IDLE, DETECT, REQUEST, SERVED}.
- One sub-module, sensor_debounce (synchronizer plus debounce counter; parameter DEBOUNCE_CYC; outputs deb and deb_rise).
- Tick and FSM stay in the top level.

Test Plan:
- Bench parameters: TICK_CYC=10, DEBOUNCE_CYC=4, MIN_PRESENCE_S=2, MAX_WAIT_S=3.
- Scenarios:
  1. Reset then raw rise at cycle 0 (light=100) -> deb=1 at cycle 6, C=1 at cycle 27, waiting_cnt=1, urgent=0.
  2. 3-cycle raw pulse repeated 5 times, 3 cycles apart -> deb never rises, C stays 0, waiting_cnt=0.
  3. Request held with light=100 for 40 cycles after C rises -> wait_s=3 at cycle 30 after C, urgent=1 from then; raw dropped mid-wait -> C stays 1.
  4. During REQUEST, light=001 -> C=0 and wait_s=0, waiting_cnt=0, urgent=0 next cycle. Then light=100 with deb=1 -> IDLE, then DETECT one cycle later.
  5. Vehicle present at DETECT entry, 17 clean arrivals before grant -> waiting_cnt saturates at 15, no wrap.
  6. rst asserted for 1 cycle while in REQUEST with wait_s=2 -> next cycle C=0, wait_s=0, waiting_cnt=0, state IDLE.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings and sensor FSM state type for the highway/farm traffic-light blocks.
package traffic_pkg;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {IDLE, DETECT, REQUEST, SERVED} sensor_state_e;
endpackage

// File: rtl/farm_sensor_request_if.sv
// Sensor/lamp inputs and request/status outputs of the farm-road vehicle detector.
interface farm_sensor_request_if;
  logic       sensor_raw;
  logic [2:0] farm_light;
  logic       C;
  logic [3:0] waiting_cnt;
  logic [7:0] wait_s;
  logic       urgent;

  modport master (output sensor_raw, farm_light, input C, waiting_cnt, wait_s, urgent);
  modport slave  (input sensor_raw, farm_light, output C, waiting_cnt, wait_s, urgent);
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus stable-count debounce; deb_rise pulses with the cycle deb first reads 1.
module sensor_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic deb_rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[0], raw};
    cnt_d  = '0;
    deb_d  = deb_q;
    rise_d = 1'b0;
    // The counter only advances while the synced level disagrees; the last mismatch cycle flips deb.
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d  = ~deb_q;
        rise_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
    end
  end

  assign deb      = deb_q;
  assign deb_rise = rise_q;
endmodule

// File: rtl/farm_sensor_request.sv
// Farm-road vehicle detector: qualifies presence, latches request C until farm green, reports wait status.
module farm_sensor_request
  import traffic_pkg::*;
#(
  parameter int TICK_CYC       = 50_000_000,
  parameter int DEBOUNCE_CYC   = 500_000,
  parameter int MIN_PRESENCE_S = 2,
  parameter int MAX_WAIT_S     = 9
) (
  input logic                  clk,
  input logic                  rst,
  farm_sensor_request_if.slave bus
);
  localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
  localparam logic [7:0] PRES_MAX = 8'(MIN_PRESENCE_S);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT_S);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic deb, deb_rise, green, tick, entered;
  sensor_state_e     state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        presence_q, presence_d;
  logic [7:0]        wait_q, wait_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              c_q, c_d;
  logic              urgent_q, urgent_d;

  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk      (clk),
    .rst      (rst),
    .raw      (bus.sensor_raw),
    .deb      (deb),
    .deb_rise (deb_rise)
  );

  assign green = (bus.farm_light == LIGHT_GREEN);
  assign tick  = (tick_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    presence_d = presence_q;
    wait_d     = wait_q;
    case (state_q)
      IDLE:    if (!green && deb) state_d = DETECT;
      DETECT: begin
        if (green)     state_d = SERVED;
        else if (!deb) state_d = IDLE;
        else if (tick) begin
          if (presence_q + 8'd1 >= PRES_MAX) state_d = REQUEST;
          else                               presence_d = presence_q + 8'd1;
        end
      end
      REQUEST: begin
        if (green)     state_d = SERVED;
        else if (tick) wait_d = sat_inc8(wait_q);
      end
      SERVED:  if (!green) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    entered = (state_d != state_q);
    if (entered) presence_d = '0;
    if (state_d != REQUEST) wait_d = '0;

    // Restarting the tick on DETECT/REQUEST entry makes presence and wait durations exact.
    tick_d = tick ? '0 : tick_q + 1'b1;
    if (entered && (state_d == DETECT || state_d == REQUEST)) tick_d = '0;

    cnt_d = deb_rise ? sat_inc4(cnt_q) : cnt_q;
    if (entered && state_d == SERVED) cnt_d = '0;

    c_d      = (state_d == REQUEST);
    urgent_d = (state_d == REQUEST) && (wait_d >= WAIT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      presence_q <= '0;
      wait_q     <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      urgent_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      presence_q <= presence_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      urgent_q   <= urgent_d;
    end
  end

  assign bus.C           = c_q;
  assign bus.waiting_cnt = cnt_q;
  assign bus.wait_s      = wait_q;
  assign bus.urgent      = urgent_q;
endmodule

// File: tb/tb_farm_sensor_request.sv
// Directed bench for farm_sensor_request with shortened tick/debounce timing.
module tb_farm_sensor_request;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  farm_sensor_request_if bus();

  farm_sensor_request #(
    .TICK_CYC(10), .DEBOUNCE_CYC(4), .MIN_PRESENCE_S(2), .MAX_WAIT_S(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.sensor_raw = 1'b0; bus.farm_light = 3'b100;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.C !== 1'b0) begin errors++; $display("FAIL reset_C: got %0b want 0", bus.C); end
    checks++; if (bus.waiting_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.waiting_cnt); end
    checks++; if (bus.wait_s !== 8'd0) begin errors++; $display("FAIL reset_wait: got %0d want 0", bus.wait_s); end
    checks++; if (bus.urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent: got %0b want 0", bus.urgent); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_raise_request();
    do_reset();
    bus.sensor_raw = 1'b1;
    step(5);
    checks++; if (dut.deb !== 1'b0) begin errors++; $display("FAIL s1_deb_early: got %0b want 0", dut.deb); end
    step(1);
    checks++; if (dut.deb !== 1'b1) begin errors++; $display("FAIL s1_deb_at6: got %0b want 1", dut.deb); end
    step(20);
    checks++; if (bus.C !== 1'b0) begin errors++; $display("FAIL s1_C_early: got %0b want 0", bus.C); end
    step(1);
    checks++; if (bus.C !== 1'b1) begin errors++; $display("FAIL s1_C_at27: got %0b want 1", bus.C); end
    checks++; if (bus.waiting_cnt !== 4'd1) begin errors++; $display("FAIL s1_cnt: got %0d want 1", bus.waiting_cnt); end
    checks++; if (bus.urgent !== 1'b0) begin errors++; $display("FAIL s1_urgent: got %0b want 0", bus.urgent); end
  endtask

  task automatic test_wait_urgent();
    step(29);
    checks++; if (bus.wait_s !== 8'd2) begin errors++; $display("FAIL s3_wait29: got %0d want 2", bus.wait_s); end
    checks++; if (bus.urgent !== 1'b0) begin errors++; $display("FAIL s3_urgent29: got %0b want 0", bus.urgent); end
    step(1);
    checks++; if (bus.wait_s !== 8'd3) begin errors++; $display("FAIL s3_wait30: got %0d want 3", bus.wait_s); end
    checks++; if (bus.urgent !== 1'b1) begin errors++; $display("FAIL s3_urgent30: got %0b want 1", bus.urgent); end
    bus.sensor_raw = 1'b0;
    step(15);
    checks++; if (dut.deb !== 1'b0) begin errors++; $display("FAIL s3_deb_fall: got %0b want 0", dut.deb); end
    checks++; if (bus.C !== 1'b1) begin errors++; $display("FAIL s3_C_latched: got %0b want 1", bus.C); end
    checks++; if (bus.wait_s !== 8'd4) begin errors++; $display("FAIL s3_wait45: got %0d want 4", bus.wait_s); end
    checks++; if (bus.urgent !== 1'b1) begin errors++; $display("FAIL s3_urgent45: got %0b want 1", bus.urgent); end
  endtask

  task automatic test_grant();
    bus.sensor_raw = 1'b1;
    step(7);
    checks++; if (bus.waiting_cnt !== 4'd2) begin errors++; $display("FAIL s4_cnt_pre: got %0d want 2", bus.waiting_cnt); end
    bus.farm_light = 3'b001;
    step(1);
    checks++; if (bus.C !== 1'b0) begin errors++; $display("FAIL s4_C: got %0b want 0", bus.C); end
    checks++; if (bus.wait_s !== 8'd0) begin errors++; $display("FAIL s4_wait: got %0d want 0", bus.wait_s); end
    checks++; if (bus.waiting_cnt !== 4'd0) begin errors++; $display("FAIL s4_cnt: got %0d want 0", bus.waiting_cnt); end
    checks++; if (bus.urgent !== 1'b0) begin errors++; $display("FAIL s4_urgent: got %0b want 0", bus.urgent); end
    checks++; if (dut.state_q !== SERVED) begin errors++; $display("FAIL s4_served: got %0d want SERVED", dut.state_q); end
    bus.farm_light = 3'b100;
    step(1);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL s4_idle: got %0d want IDLE", dut.state_q); end
    step(1);
    checks++; if (dut.state_q !== DETECT) begin errors++; $display("FAIL s4_detect: got %0d want DETECT", dut.state_q); end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.sensor_raw = 1'b1; step(3);
      bus.sensor_raw = 1'b0; step(3);
    end
    step(10);
    checks++; if (dut.deb !== 1'b0) begin errors++; $display("FAIL s2_deb: got %0b want 0", dut.deb); end
    checks++; if (bus.C !== 1'b0) begin errors++; $display("FAIL s2_C: got %0b want 0", bus.C); end
    checks++; if (bus.waiting_cnt !== 4'd0) begin errors++; $display("FAIL s2_cnt: got %0d want 0", bus.waiting_cnt); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL s2_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_green_ignore();
    do_reset();
    bus.farm_light = 3'b001; bus.sensor_raw = 1'b1;
    step(10);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL gi_idle: got %0d want IDLE", dut.state_q); end
    checks++; if (bus.C !== 1'b0) begin errors++; $display("FAIL gi_C: got %0b want 0", bus.C); end
    bus.farm_light = 3'b100;
    step(1);
    checks++; if (dut.state_q !== DETECT) begin errors++; $display("FAIL gi_detect: got %0d want DETECT", dut.state_q); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.sensor_raw = 1'b1;
    step(7);
    checks++; if (dut.state_q !== DETECT) begin errors++; $display("FAIL s5_detect: got %0d want DETECT", dut.state_q); end
    checks++; if (bus.waiting_cnt !== 4'd1) begin errors++; $display("FAIL s5_cnt1: got %0d want 1", bus.waiting_cnt); end
    for (int i = 0; i < 14; i++) begin
      bus.sensor_raw = 1'b0; step(6);
      bus.sensor_raw = 1'b1; step(6);
    end
    step(1);
    checks++; if (bus.waiting_cnt !== 4'd15) begin errors++; $display("FAIL s5_cnt15: got %0d want 15", bus.waiting_cnt); end
    for (int i = 0; i < 2; i++) begin
      bus.sensor_raw = 1'b0; step(6);
      bus.sensor_raw = 1'b1; step(6);
    end
    step(1);
    checks++; if (bus.waiting_cnt !== 4'd15) begin errors++; $display("FAIL s5_sat: got %0d want 15", bus.waiting_cnt); end
    bus.farm_light = 3'b001;
    step(1);
    checks++; if (dut.state_q !== SERVED) begin errors++; $display("FAIL s5_served: got %0d want SERVED", dut.state_q); end
    checks++; if (bus.waiting_cnt !== 4'd0) begin errors++; $display("FAIL s5_clear: got %0d want 0", bus.waiting_cnt); end
    bus.farm_light = 3'b100;
  endtask

  task automatic test_reset_mid_request();
    do_reset();
    bus.sensor_raw = 1'b1;
    step(27);
    checks++; if (bus.C !== 1'b1) begin errors++; $display("FAIL s6_C: got %0b want 1", bus.C); end
    bus.farm_light = 3'b011;
    step(20);
    checks++; if (bus.C !== 1'b1) begin errors++; $display("FAIL s6_nonhot: got %0b want 1", bus.C); end
    checks++; if (bus.wait_s !== 8'd2) begin errors++; $display("FAIL s6_wait: got %0d want 2", bus.wait_s); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (bus.C !== 1'b0) begin errors++; $display("FAIL s6_rst_C: got %0b want 0", bus.C); end
    checks++; if (bus.wait_s !== 8'd0) begin errors++; $display("FAIL s6_rst_wait: got %0d want 0", bus.wait_s); end
    checks++; if (bus.waiting_cnt !== 4'd0) begin errors++; $display("FAIL s6_rst_cnt: got %0d want 0", bus.waiting_cnt); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL s6_rst_state: got %0d want IDLE", dut.state_q); end
    bus.farm_light = 3'b100;
  endtask

  initial begin
    bus.sensor_raw = 1'b0;
    bus.farm_light = 3'b100;
    test_reset();
    test_raise_request();
    test_wait_urgent();
    test_grant();
    test_glitch();
    test_green_ignore();
    test_saturate();
    test_reset_mid_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
